capture_sequencer: RTL and testbench
====================================

Name: capture_sequencer

Overview:
- Sequences a logic-capture run and owns write-side control of the trace RAM.
- Takes the registered sample plus the trigger and transition flags from the trigger/transition detection stage.
- Builds run-length-encoded sample packets and writes them into a circular buffer. It enforces a configurable pre-trigger depth and post-trigger length.
- When a run finishes, reports the oldest-packet address, trigger-packet address and packet count, so the host readout logic can unload the trace.

Parameters:
- SAMPLE_WIDTH, 8: sample channels per packet.
- DELTA_WIDTH, 8: run-length (delta) field width.
- ADDR_WIDTH, 10: trace RAM address width; DEPTH = 2**ADDR_WIDTH packets.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- start  in  1  single-cycle pulse; begins a run.
- abort  in  1  single-cycle pulse; cancels a run.
- sample  in  SAMPLE_WIDTH  current registered sample.
- triggered  in  1  trigger condition true this cycle.
- transition  in  1  sample differs from the previous sample on active channels.
- pre_depth  in  ADDR_WIDTH  packets required before a trigger is accepted; values ≥ DEPTH clamp to DEPTH-1.
- post_depth  in  ADDR_WIDTH  packets written after the trigger packet.
- mem_we  out  1  trace RAM write enable.
- mem_addr  out  ADDR_WIDTH  write address.
- mem_wdata  out  DELTA_WIDTH+SAMPLE_WIDTH  packet {delta, sample}.
- idle  out  1  state IDLE.
- running  out  1  state PRE_FILL or ARMED.
- post_trigger  out  1  state POST.
- complete  out  1  state DONE.
- trig_addr  out  ADDR_WIDTH  address of the trigger packet.
- first_addr  out  ADDR_WIDTH  address of the oldest valid packet.
- pkt_count  out  ADDR_WIDTH+1  valid packets in the buffer, at most DEPTH.

Behaviour:
- Reset:
  - State is IDLE; all outputs are 0 except idle=1.
  - wr_ptr=0, delta_cnt=0, written=0.
  - pre_depth and post_depth are latched at start and held for the whole run.
- States:
  - IDLE: start → PRE_FILL.
  - PRE_FILL: once written ≥ pre_depth → ARMED. triggered is ignored in this state. If pre_depth=0, move to ARMED on the cycle after start.
  - ARMED: triggered → POST, or → DONE if post_depth=0.
  - POST: after post_depth packets following the trigger packet → DONE.
  - DONE: start → PRE_FILL (new run; counters cleared).
  - Any state: abort → IDLE next cycle. No further writes; complete stays 0.
  - abort takes priority when it coincides with start.
  - start is ignored in PRE_FILL, ARMED and POST.
- Packet writes happen only in PRE_FILL, ARMED or POST. A packet is written in any cycle where one of these holds:
  - it is the first cycle of the run;
  - transition=1;
  - delta_cnt = 2**DELTA_WIDTH-1;
  - it is the trigger-accept cycle in ARMED.
- Write-cycle outputs:
  - mem_we=1, mem_addr=wr_ptr, mem_wdata={delta_cnt, sample}.
  - The first packet carries delta=0.
  - These outputs are registered: they appear one cycle after the sample is presented.
- Counter updates:
  - On a write: wr_ptr ← wr_ptr+1, wrapping DEPTH-1→0. delta_cnt ← 1. written ← written+1, saturating at DEPTH.
  - Otherwise: delta_cnt ← delta_cnt+1.
  - The stored delta therefore never exceeds 2**DELTA_WIDTH-1.
- Trigger accept: trig_addr ← wr_ptr in the accept cycle.
- Post-trigger: a counter counts packets written in POST. The transition to DONE happens on the cycle of the post_depth-th write.
- Wrap-around: in ARMED and POST the buffer overwrites the oldest packets indefinitely. pkt_count saturates at DEPTH. If pre_depth+1+post_depth > DEPTH, the oldest pre-trigger packets are lost; this is not an error.
- Readout values, valid whenever complete=1 and held until the next start:
  - pkt_count = written.
  - first_addr = (wr_ptr − pkt_count) mod DEPTH.
- Reset mid-run: returns to IDLE next cycle; trace RAM contents are left unchanged.

Test Plan:
- reset; start with pre_depth=4, post_depth=3, transition every cycle, triggered at cycle 10 → packets at addr 0..; trig_addr=10; complete after 3 more writes; pkt_count=14; first_addr=0.
- constant sample for 300 cycles in ARMED (DELTA_WIDTH=8) → a packet every 255 cycles with delta=255; no packet has delta>255.
- triggered asserted throughout PRE_FILL with pre_depth=5 → no trigger accepted until 5 packets written; trigger packet at addr 5.
- ADDR_WIDTH=4, pre_depth=8, 40 transitions before trigger, post_depth=4 → wr_ptr wraps; pkt_count=16; first_addr=(wr_ptr−16) mod 16; trig_addr consistent.
- abort during POST → next cycle idle=1, mem_we=0, complete=0; a following start begins a new run at wr_ptr=0 with delta=0.
- post_depth=0, trigger in ARMED → complete=1 the cycle after the trigger write; start while DONE re-arms; start and abort together → IDLE.

Source files
------------

// File: rtl/capture_sequencer.sv
// Capture sequencer: runs the pre-fill / armed / post-trigger sequence of a
// logic-capture run. It writes run-length-encoded {delta, sample} packets into
// a circular trace RAM and reports where the finished trace lives.
module capture_sequencer #(
    parameter int SAMPLE_WIDTH = 8,
    parameter int DELTA_WIDTH  = 8,
    parameter int ADDR_WIDTH   = 10
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                start,
    input  logic                                abort,
    input  logic [SAMPLE_WIDTH-1:0]             sample,
    input  logic                                triggered,
    input  logic                                transition,
    input  logic [ADDR_WIDTH-1:0]               pre_depth,
    input  logic [ADDR_WIDTH-1:0]               post_depth,
    output logic                                mem_we,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [DELTA_WIDTH+SAMPLE_WIDTH-1:0] mem_wdata,
    output logic                                idle,
    output logic                                running,
    output logic                                post_trigger,
    output logic                                complete,
    output logic [ADDR_WIDTH-1:0]               trig_addr,
    output logic [ADDR_WIDTH-1:0]               first_addr,
    output logic [ADDR_WIDTH:0]                 pkt_count
);

    // Packet count of a completely full buffer (DEPTH).
    localparam logic [ADDR_WIDTH:0]    FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    // Largest run length a packet can carry; reaching it forces a packet.
    localparam logic [DELTA_WIDTH-1:0] DELTA_MAX  = '1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE_FILL,
        S_ARMED,
        S_POST,
        S_DONE
    } state_t;

    state_t state, state_next;

    logic [ADDR_WIDTH-1:0]  wr_ptr;
    logic [DELTA_WIDTH-1:0] delta_cnt;
    logic [ADDR_WIDTH:0]    written;
    logic [ADDR_WIDTH-1:0]  post_cnt;
    logic [ADDR_WIDTH-1:0]  pre_q;
    logic [ADDR_WIDTH-1:0]  post_q;
    logic                   first_q;

    logic                   in_run;
    logic                   do_write;
    logic                   trig_accept;
    logic                   start_run;
    logic [ADDR_WIDTH:0]    written_inc;
    logic [ADDR_WIDTH-1:0]  post_cnt_inc;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic and write decision for the current cycle.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        state_next   = state;
        in_run       = (state == S_PRE_FILL) || (state == S_ARMED) || (state == S_POST);
        trig_accept  = (state == S_ARMED) && triggered && !abort;
        start_run    = start && !abort && ((state == S_IDLE) || (state == S_DONE));
        do_write     = in_run && !abort &&
                       (first_q || transition || (delta_cnt == DELTA_MAX) || trig_accept);
        written_inc  = (do_write && (written != FULL_COUNT))
                       ? written + (ADDR_WIDTH+1)'(1) : written;
        post_cnt_inc = post_cnt + ADDR_WIDTH'(1);

        if (abort) begin
            state_next = S_IDLE;
        end else begin
            case (state)
                S_IDLE:     if (start) state_next = S_PRE_FILL;
                // The count includes this cycle's packet, so arming happens
                // right after the pre_depth-th packet. pre_depth is only
                // ADDR_WIDTH bits wide, so it can never exceed DEPTH-1 and
                // needs no clamping.
                S_PRE_FILL: if (written_inc >= {1'b0, pre_q}) state_next = S_ARMED;
                S_ARMED:    if (triggered) state_next = (post_q == '0) ? S_DONE : S_POST;
                S_POST:     if (do_write && (post_cnt_inc == post_q)) state_next = S_DONE;
                S_DONE:     if (start) state_next = S_PRE_FILL;
                default:    state_next = S_IDLE;
            endcase
        end
    end

    // Run counters, latched run configuration and the registered RAM write port.
    always_ff @(posedge clk) begin
        // NOTE: only control/status registers are reset; the trace RAM itself
        // lives outside this block and keeps its contents across reset.
        if (reset) begin
            wr_ptr    <= '0;
            delta_cnt <= '0;
            written   <= '0;
            post_cnt  <= '0;
            pre_q     <= '0;
            post_q    <= '0;
            first_q   <= 1'b0;
            trig_addr <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= do_write;
            if (do_write) begin
                mem_addr  <= wr_ptr;
                mem_wdata <= {delta_cnt, sample};
            end

            if (start_run) begin
                wr_ptr    <= '0;
                delta_cnt <= '0;
                written   <= '0;
                post_cnt  <= '0;
                pre_q     <= pre_depth;
                post_q    <= post_depth;
                first_q   <= 1'b1;
                trig_addr <= '0;
            end else if (in_run && !abort) begin
                first_q <= 1'b0;
                if (do_write) begin
                    wr_ptr    <= wr_ptr + ADDR_WIDTH'(1);
                    delta_cnt <= DELTA_WIDTH'(1);
                    written   <= written_inc;
                    if (state == S_POST) begin
                        post_cnt <= post_cnt_inc;
                    end
                end else begin
                    delta_cnt <= delta_cnt + DELTA_WIDTH'(1);
                end
                if (trig_accept) begin
                    trig_addr <= wr_ptr;
                    post_cnt  <= '0;
                end
            end
        end
    end

    // Status flags decoded from the state; readout derived from the counters,
    // which stay frozen from DONE until the next start.
    always_comb begin
        idle         = (state == S_IDLE);
        running      = (state == S_PRE_FILL) || (state == S_ARMED);
        post_trigger = (state == S_POST);
        complete     = (state == S_DONE);
        pkt_count    = written;
        first_addr   = wr_ptr - written[ADDR_WIDTH-1:0];
    end

endmodule

// File: tb/tb_capture_sequencer.sv
// Directed bench for capture_sequencer: a table-driven basic run plus
// hand-written sequences for trigger gating, delta saturation, wrap-around,
// abort and re-arm. A second instance with ADDR_WIDTH=4 exercises wrap.
module tb_capture_sequencer;

    localparam int SW  = 8;
    localparam int DW  = 8;
    localparam int AW  = 10;
    localparam int AWS = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          start, abort, triggered, transition;
    logic [SW-1:0] sample;
    logic [AW-1:0] pre_depth, post_depth;

    logic              mem_we, idle, running, post_trigger, complete;
    logic [AW-1:0]     mem_addr, trig_addr, first_addr;
    logic [DW+SW-1:0]  mem_wdata;
    logic [AW:0]       pkt_count;

    logic              s_mem_we, s_idle, s_running, s_post_trigger, s_complete;
    logic [AWS-1:0]    s_mem_addr, s_trig_addr, s_first_addr;
    logic [DW+SW-1:0]  s_mem_wdata;
    logic [AWS:0]      s_pkt_count;

    always #5 clk = ~clk;

    capture_sequencer #(.SAMPLE_WIDTH(SW), .DELTA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .sample(sample),
        .triggered(triggered), .transition(transition),
        .pre_depth(pre_depth), .post_depth(post_depth),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .idle(idle), .running(running), .post_trigger(post_trigger), .complete(complete),
        .trig_addr(trig_addr), .first_addr(first_addr), .pkt_count(pkt_count)
    );

    capture_sequencer #(.SAMPLE_WIDTH(SW), .DELTA_WIDTH(DW), .ADDR_WIDTH(AWS)) dut_s (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .sample(sample),
        .triggered(triggered), .transition(transition),
        .pre_depth(pre_depth[AWS-1:0]), .post_depth(post_depth[AWS-1:0]),
        .mem_we(s_mem_we), .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata),
        .idle(s_idle), .running(s_running), .post_trigger(s_post_trigger), .complete(s_complete),
        .trig_addr(s_trig_addr), .first_addr(s_first_addr), .pkt_count(s_pkt_count)
    );

    typedef struct {
        logic          start;
        logic          abort;
        logic          trig;
        logic          trans;
        logic [SW-1:0] sample;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_delta;
        logic [3:0]    exp_flags;   // {idle, running, post_trigger, complete}
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic ab, input logic tr,
                         input logic tn, input logic [SW-1:0] smp);
        start      = st;
        abort      = ab;
        triggered  = tr;
        transition = tn;
        sample     = smp;
    endtask

    function automatic vec_t mk(input logic st, input logic tr, input logic tn,
                                input logic [SW-1:0] smp, input logic we,
                                input logic [AW-1:0] addr, input logic [DW-1:0] dl,
                                input logic [3:0] fl);
        vec_t v;
        v.start = st; v.abort = 1'b0; v.trig = tr; v.trans = tn; v.sample = smp;
        v.exp_we = we; v.exp_addr = addr; v.exp_delta = dl; v.exp_flags = fl;
        return v;
    endfunction

    initial begin
        vec_t        vecs[16];
        logic [3:0]  fl;
        int          nw, wcyc;
        logic [DW-1:0] wdelta;
        logic [AW-1:0] waddr;

        // Basic run: pre_depth=4, post_depth=3, transition every cycle,
        // trigger on run cycle 10. Packet k lands at address k.
        vecs[0] = mk(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 8'd0, 4'b0100);
        for (int k = 0; k < 14; k++) begin
            if (k <= 9)       fl = 4'b0100;
            else if (k <= 12) fl = 4'b0010;
            else              fl = 4'b0001;
            vecs[k+1] = mk(1'b0, (k == 10), 1'b1, 8'(8'h10 + k), 1'b1, AW'(k),
                           (k == 0) ? 8'd0 : 8'd1, fl);
        end
        vecs[15] = mk(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 10'd0, 8'd0, 4'b0001);

        reset = 1'b1;
        drive(0, 0, 0, 0, 8'h00);
        pre_depth  = '0;
        post_depth = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state.
        check("rst_flags", {idle, running, post_trigger, complete}, 4'b1000);
        check("rst_we", mem_we, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_trig_addr", trig_addr, 0);
        check("rst_first_addr", first_addr, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_s_flags", {s_idle, s_running, s_post_trigger, s_complete}, 4'b1000);

        // Table-driven basic run.
        pre_depth  = 10'd4;
        post_depth = 10'd3;
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].start, vecs[i].abort, vecs[i].trig, vecs[i].trans, vecs[i].sample);
            step();
            check($sformatf("t1_flags[%0d]", i), {idle, running, post_trigger, complete},
                  vecs[i].exp_flags);
            check($sformatf("t1_we[%0d]", i), mem_we, vecs[i].exp_we);
            if (vecs[i].exp_we) begin
                check($sformatf("t1_addr[%0d]", i), mem_addr, vecs[i].exp_addr);
                check($sformatf("t1_wdata[%0d]", i), mem_wdata,
                      {vecs[i].exp_delta, vecs[i].sample});
            end
        end
        check("t1_trig_addr", trig_addr, 10);
        check("t1_pkt_count", pkt_count, 14);
        check("t1_first_addr", first_addr, 0);

        // Trigger held through PRE_FILL: not accepted before 5 packets.
        pre_depth  = 10'd5;
        post_depth = 10'd2;
        drive(1, 0, 1, 0, 8'h00);
        step();
        check("t3_start_running", running, 1);
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 1, 1, 8'(8'h40 + i));
            step();
            check($sformatf("t3_no_trig[%0d]", i), {post_trigger, complete}, 2'b00);
            check($sformatf("t3_addr[%0d]", i), mem_addr, i);
        end
        drive(0, 0, 1, 1, 8'h45);
        step();
        check("t3_post", post_trigger, 1);
        check("t3_trig_write_addr", mem_addr, 5);
        check("t3_trig_addr", trig_addr, 5);
        repeat (2) begin
            drive(0, 0, 1, 1, 8'h46);
            step();
        end
        check("t3_complete", complete, 1);
        check("t3_pkt_count", pkt_count, 8);
        check("t3_first_addr", first_addr, 0);

        // post_depth=0: DONE right after the trigger write; start re-arms from DONE.
        pre_depth  = 10'd0;
        post_depth = 10'd0;
        drive(1, 0, 0, 0, 8'h00);
        step();
        check("t6_rearm_running", running, 1);
        drive(0, 0, 0, 0, 8'h3C);
        step();
        check("t6_first_addr_w", mem_addr, 0);
        check("t6_first_wdata", mem_wdata, {8'd0, 8'h3C});
        check("t6_armed", running, 1);
        drive(0, 0, 1, 0, 8'h3D);
        step();
        check("t6_complete", complete, 1);
        check("t6_trig_we", mem_we, 1);
        check("t6_trig_wdata", {6'd0, mem_addr, mem_wdata}, {6'd0, 10'd1, 8'd1, 8'h3D});
        check("t6_trig_addr", trig_addr, 1);
        check("t6_pkt_count", pkt_count, 2);
        check("t6_first_addr", first_addr, 0);
        drive(1, 1, 0, 0, 8'h00);
        step();
        check("t6_start_abort_idle", {idle, running, post_trigger, complete}, 4'b1000);
        drive(0, 0, 0, 0, 8'h00);

        // Abort during POST, then a fresh run from address 0 with delta 0.
        pre_depth  = 10'd0;
        post_depth = 10'd5;
        drive(1, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 0, 1, 8'h01);
        step();
        drive(0, 0, 1, 1, 8'h02);
        step();
        check("t5_in_post", post_trigger, 1);
        drive(0, 0, 0, 1, 8'h03);
        step();
        drive(0, 1, 0, 1, 8'h04);
        step();
        check("t5_abort_idle", idle, 1);
        check("t5_abort_we", mem_we, 0);
        check("t5_abort_complete", complete, 0);
        post_depth = 10'd0;
        drive(1, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 0, 1, 8'hA5);
        step();
        check("t5_new_we", mem_we, 1);
        check("t5_new_addr", mem_addr, 0);
        check("t5_new_wdata", mem_wdata, {8'd0, 8'hA5});
        drive(0, 1, 0, 0, 8'h00);
        step();
        check("t5_end_idle", idle, 1);

        // Constant sample in ARMED: one saturated packet every 255 cycles.
        pre_depth  = 10'd0;
        post_depth = 10'd5;
        drive(1, 0, 0, 0, 8'h00);
        step();
        drive(0, 0, 0, 0, 8'h77);
        step();
        check("t2_first_we", mem_we, 1);
        check("t2_first_wdata", mem_wdata, {8'd0, 8'h77});
        nw = 0; wcyc = 0; wdelta = '0; waddr = '0;
        for (int i = 1; i <= 300; i++) begin
            step();
            if (mem_we) begin
                nw++;
                wcyc   = i;
                wdelta = mem_wdata[DW+SW-1:SW];
                waddr  = mem_addr;
            end
        end
        check("t2_write_count", nw, 1);
        check("t2_write_cycle", wcyc, 255);
        check("t2_delta", wdelta, 255);
        check("t2_addr", waddr, 1);
        check("t2_still_armed", running, 1);
        drive(0, 1, 0, 0, 8'h00);
        step();
        check("t2_abort_idle", idle, 1);

        // Wrap-around on the 16-entry instance: 40 packets, trigger, 4 post.
        pre_depth  = 10'd8;
        post_depth = 10'd4;
        drive(1, 0, 0, 0, 8'h00);
        step();
        for (int k = 0; k < 40; k++) begin
            drive(0, 0, 0, 1, 8'(k));
            step();
        end
        drive(0, 0, 1, 1, 8'hF0);
        step();
        check("t4_s_trig_write_addr", s_mem_addr, 8);
        check("t4_trig_write_addr", mem_addr, 40);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 0, 1, 8'(8'hF1 + k));
            step();
        end
        drive(0, 0, 0, 0, 8'h00);
        check("t4_s_complete", s_complete, 1);
        check("t4_s_trig_addr", s_trig_addr, 8);
        check("t4_s_pkt_count", s_pkt_count, 16);
        check("t4_s_first_addr", s_first_addr, 13);
        check("t4_complete", complete, 1);
        check("t4_trig_addr", trig_addr, 40);
        check("t4_pkt_count", pkt_count, 45);
        check("t4_first_addr", first_addr, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
